// File: rtl/i2c_slave_receiver.sv
// Write-only I2C responder: detects START/STOP, ACKs its own address with R/W=0,
// then receives and ACKs data bytes, handing each one to the fabric with a strobe.
module i2c_slave_receiver #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_drop,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det
);

  // state    | meaning
  // IDLE     | bus free or not ours, wait for START
  // ADDR     | shifting in the address byte
  // ADDR_ACK | driving ACK for a matching write address
  // DATA     | shifting in a data byte
  // DATA_ACK | deliver/drop the byte, then ACK or NACK it
  // IGNORE   | address not ours or a read, wait for START/STOP
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, sda_in;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic       ack_phase_q, ack_phase_d;
  logic       eval_q, eval_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addressed_q, addressed_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_drop_q, rx_drop_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  assign sda    = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in = sda;

  // Synchronisers reset to the idle-bus level so release from reset makes no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_cond = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      ack_q       <= 1'b0;
      ack_phase_q <= 1'b0;
      eval_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_drop_q   <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      ack_phase_q <= ack_phase_d;
      eval_q      <= eval_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_drop_q   <= rx_drop_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    ack_phase_d = ack_phase_q;
    eval_d      = eval_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_drop_d   = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    if (start_cond) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd7;
      shift_d     = 8'h00;
      ack_phase_d = 1'b0;
      eval_d      = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_cond) begin
      state_d     = IDLE;
      ack_phase_d = 1'b0;
      eval_d      = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_det_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: sda_oe_d = 1'b0;
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d   = 3'd7;
            ack_phase_d = 1'b0;
            state_d     = (shift_d[7:1] == SLAVE_ADDR && !shift_d[0]) ? ADDR_ACK : IGNORE;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            ack_phase_d = 1'b1;
            sda_oe_d    = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b1;
            bit_cnt_d   = 3'd7;
            state_d     = DATA;
          end
        end
        DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d   = 3'd7;
            ack_phase_d = 1'b0;
            eval_d      = 1'b1;
            state_d     = DATA_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        DATA_ACK: begin
          // First cycle decides accept/drop; then the 9th clock is walked with or without ACK.
          if (eval_q) begin
            eval_d = 1'b0;
            ack_d  = rx_ready;
            if (rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_drop_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_oe_d    = ack_q;
            end else begin
              ack_phase_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = DATA;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_drop   = rx_drop_q;
  assign addressed = addressed_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule
